// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer for the shared Hack ALU.
// Ports: clk/reset_n; start,a,b in; busy,done,product,prod_zr,prod_ng out;
//        alu_x/alu_y/alu_{zx,nx,zy,ny,f,no} drive the ALU, alu_out returns.
module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             prod_zr,
   output logic             prod_ng,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic             alu_zx,
   output logic             alu_nx,
   output logic             alu_zy,
   output logic             alu_ny,
   output logic             alu_f,
   output logic             alu_no,
   input  logic [WIDTH-1:0] alu_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DBL  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] acc, acc_d;
   logic [WIDTH-1:0] m, m_d;
   logic [WIDTH-1:0] q, q_d;
   logic [WIDTH-1:0] q_sh;

   function automatic state_t decide(input logic [WIDTH-1:0] v);
      state_t s;
      unique case (1'b1)
         (v == '0): s = DONE;
         v[0]:      s = ADD;
         default:   s = DBL;
      endcase
      return s;
   endfunction

   assign q_sh = q >> 1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         acc   <= '0;
         m     <= '0;
         q     <= '0;
      end else begin
         state <= state_d;
         acc   <= acc_d;
         m     <= m_d;
         q     <= q_d;
      end
   end

   always_comb begin
      state_d = state;
      acc_d   = acc;
      m_d     = m;
      q_d     = q;
      // Idle drive is the ALU "constant 0" code.
      alu_x   = '0;
      alu_y   = '0;
      alu_zx  = 1'b1;
      alu_nx  = 1'b0;
      alu_zy  = 1'b1;
      alu_ny  = 1'b0;
      alu_f   = 1'b1;
      alu_no  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               m_d     = a;
               q_d     = b;
               state_d = decide(b);
            end
         end
         ADD: begin
            alu_x   = acc;
            alu_y   = m;
            alu_zx  = 1'b0;
            alu_zy  = 1'b0;
            acc_d   = alu_out;
            state_d = (q[WIDTH-1:1] == '0) ? DONE : DBL;
         end
         DBL: begin
            alu_x   = m;
            alu_y   = m;
            alu_zx  = 1'b0;
            alu_zy  = 1'b0;
            m_d     = alu_out;
            q_d     = q_sh;
            // q_sh is nonzero here, so this never selects DONE.
            state_d = decide(q_sh);
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = (state == ADD) || (state == DBL);
   assign done    = (state == DONE);
   assign product = acc;
   assign prod_zr = (acc == '0);
   assign prod_ng = acc[WIDTH-1];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural Hack ALU attached.
// Ports: drives clk/reset_n/start/a/b, closes the ALU loop, checks outputs.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] product;
   logic        prod_zr, prod_ng;
   logic [15:0] alu_x, alu_y, alu_out;
   logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

   int total = 0;
   int bad   = 0;

   alu_mul_seq #(.WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .prod_zr (prod_zr),
      .prod_ng (prod_ng),
      .alu_x   (alu_x),
      .alu_y   (alu_y),
      .alu_zx  (alu_zx),
      .alu_nx  (alu_nx),
      .alu_zy  (alu_zy),
      .alu_ny  (alu_ny),
      .alu_f   (alu_f),
      .alu_no  (alu_no),
      .alu_out (alu_out)
   );

   always #5 clk = ~clk;

   // Hack ALU
   logic [15:0] x1, x2, y1, y2, fo;
   always_comb begin
      x1      = alu_zx ? 16'h0 : alu_x;
      x2      = alu_nx ? ~x1 : x1;
      y1      = alu_zy ? 16'h0 : alu_y;
      y2      = alu_ny ? ~y1 : y1;
      fo      = alu_f ? (x2 + y2) : (x2 & y2);
      alu_out = alu_no ? ~fo : fo;
   end

   wire [5:0] ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive start for one accepting edge; returns in cycle 1.
   task automatic go(input logic [15:0] av, input logic [15:0] bv);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(negedge clk);
      start = 1'b0;
      a     = 16'hDEAD;
      b     = 16'hBEEF;
   endtask

   // Called in cycle 1; reports done cycle, busy cycles, control errors.
   task automatic wait_done(output int n, output int nbusy,
                            output int cerr);
      int c = 1;
      nbusy = 0;
      cerr  = 0;
      forever begin
         if (busy) nbusy++;
         if (busy && done) cerr++;
         if (ctrl !== (busy ? 6'b000010 : 6'b101010)) cerr++;
         if (done || c >= 64) break;
         @(negedge clk);
         c++;
      end
      n = done ? c : -1;
   endtask

   task automatic run(input string tag, input logic [15:0] av,
                      input logic [15:0] bv, input logic [15:0] ep,
                      input int en);
      int n, nb, ce;
      go(av, bv);
      wait_done(n, nb, ce);
      chk({tag, "_lat"}, n, en);
      chk({tag, "_prod"}, product, ep);
      chk({tag, "_zr"}, prod_zr, (ep == 16'h0));
      chk({tag, "_ng"}, prod_ng, ep[15]);
      chk({tag, "_busy"}, nb, en - 1);
      chk({tag, "_ctrl"}, ce, 0);
      @(negedge clk);
   endtask

   initial begin
      int n, nb, ce, seen;
      reset_n = 1'b0;
      start   = 1'b0;
      a       = 16'h0;
      b       = 16'h0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_prod", product, 0);
      chk("rst_zr", prod_zr, 1);
      chk("rst_ctrl", ctrl, 6'b101010);
      reset_n = 1'b1;
      @(negedge clk);

      run("m3x5", 16'd3, 16'd5, 16'd15, 5);
      run("mneg", 16'hFFF9, 16'd9, 16'hFFC1, 6);
      run("mb0", 16'h1234, 16'h0, 16'h0, 1);
      run("mwrap", 16'h0100, 16'h0100, 16'h0, 10);
      run("mfull", 16'hFFFF, 16'hFFFF, 16'h0001, 32);

      // start held high; operands change while busy
      start = 1'b1;
      a     = 16'd3;
      b     = 16'd5;
      @(negedge clk);
      a = 16'd7;
      b = 16'd7;
      wait_done(n, nb, ce);
      chk("hold_lat", n, 5);
      chk("hold_prod", product, 16'd15);
      @(negedge clk);
      chk("hold_idle", {busy, done}, 2'b00);
      chk("hold_stable", product, 16'd15);
      @(negedge clk);
      start = 1'b0;
      wait_done(n, nb, ce);
      chk("hold2_lat", n, 6);
      chk("hold2_prod", product, 16'd49);
      @(negedge clk);

      // mid-operation reset
      go(16'd2, 16'hFFFF);
      repeat (9) @(negedge clk);
      chk("mid_busy", busy, 1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_prod", product, 0);
      chk("mr_ctrl", ctrl, 6'b101010);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("mr_nodone", seen, 0);
      run("m4x4", 16'd4, 16'd4, 16'd16, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
